lab3_test_mem_responder: RTL and testbench
==========================================

// Module: lab3_test_mem_responder
// PURPOSE
//  Memory-side responder for the 4B mem_req/mem_resp val/rdy protocol, i.e. the
//  far end of the cache's refill/evict port. Accepts one mem_req_4B_t at a time,
//  applies it to an internal word array after a programmable latency, and returns
//  one mem_resp_4B_t. Serves as the main-memory model behind the lab3 caches in
//  unit and integration benches.
// PARAMETERS
//  p_num_words  4096  words of storage; power of two; index = addr[clog2(p_num_words)+1:2]
//  p_latency    2     extra cycles between accept and memresp_val (0..15)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  memreq_val   in   1   request valid
//  memreq_rdy   out  1   responder can accept request
//  memreq_msg   in   77  mem_req_4B_t {type_,opaque,addr,len,data}
//  memresp_val  out  1   response valid
//  memresp_rdy  in   1   consumer can accept response
//  memresp_msg  out  47  mem_resp_4B_t {type_,opaque,test,len,data}
//  num_reqs     out  32  count of accepted requests (wraps at 2^32)
// BEHAVIOUR
//  Reset: state=IDLE, memreq_rdy=1 in first post-reset cycle, memresp_val=0,
//   memresp_msg=0, num_reqs=0. Array contents NOT cleared; reset mid-operation
//   drops any in-flight request, no response is produced.
//  FSM: IDLE --(memreq_val&&memreq_rdy)--> (p_latency==0 ? RESP : WAIT)
//       WAIT: cnt decrements each cycle; cnt==1 -> RESP
//       RESP --(memresp_rdy)--> IDLE
//  memreq_rdy = (state==IDLE); one outstanding request max; no accept in RESP.
//  Accept edge: latch type_/opaque/len; for WRITE/INIT update array at this edge;
//   for READ capture array word into resp data reg. num_reqs++.
//  Latency: accept at edge E -> memresp_val=1 from cycle E+1+p_latency, held with
//   memresp_msg stable until memresp_rdy; memresp_val=0 cycle after handshake.
//  Types: READ=0, WRITE=1, INIT=2; other types treated as READ.
//   Response echoes type_, opaque, len; test=2'b00.
//  len: 0 = 4 bytes; 1..3 = that many bytes starting at byte addr[1:0].
//   Write: byte-enable lanes [addr[1:0] +: len]; bytes past lane 3 dropped.
//   Read: data = word >> (8*addr[1:0]), masked to len bytes (len 0: no mask).
//   WRITE/INIT response data = 0.
//  Address: byte address; addr[1:0] ignored when len==0.
//  Out-of-range (addr >= 4*p_num_words): without macro, index wraps modulo
//   p_num_words.
// CONFIGURATION
//  LAB3_MEM_RESP_ERR_EN defined: out-of-range request -> no array write, response
//   test=2'b11, data=0, normal latency. Undefined: modulo wrap, test always 00.
// TESTING
//  1 p_latency=0: WRITE addr 0x100 data 0xdeadbeef, then READ 0x100 -> resp type
//    0, data 0xdeadbeef, memresp_val 1 cycle after each accept.
//  2 p_latency=3: READ accepted at cycle 10 -> memresp_val first high cycle 14;
//    memreq_rdy=0 cycles 11..resp handshake.
//  3 memresp_rdy held 0 for 5 cycles -> memresp_val/msg stable, memreq_rdy=0,
//    second memreq_val not accepted; num_reqs increments once.
//  4 WRITE 0x200 0x11223344 len0; WRITE 0x201 data 0xaa len1 -> READ 0x200 =
//    0x1122aa44; READ 0x202 len2 = 0x00001122.
//  5 16 READs addr 0x40..0x7c (cache line refill), opaque 0..15 -> 16 responses
//    in order, opaque echoed, num_reqs=16.
//  6 reset asserted in WAIT -> no response; memreq_rdy=1 after reset; array data
//    at 0x100 still 0xdeadbeef. With LAB3_MEM_RESP_ERR_EN, p_num_words=4096:
//    READ 0x4000 -> test=2'b11, data 0.

Source files
------------

// File: rtl/lab3_test_mem_responder.sv
// Memory-side responder for the 4B mem_req/mem_resp val/rdy protocol.
// One outstanding request; response returned after p_latency extra cycles.
// Optional build macro LAB3_MEM_RESP_ERR_EN: out-of-range requests are
// flagged (test=2'b11, data=0, no write) instead of wrapping modulo the array.
module lab3_test_mem_responder #(
  parameter int unsigned p_num_words = 4096,
  parameter int unsigned p_latency   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic [76:0] memreq_msg,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic [46:0] memresp_msg,
  output logic [31:0] num_reqs
);

  localparam int unsigned IDX_W = (p_num_words > 1) ? $clog2(p_num_words) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] TYPE_INIT  = 3'd2;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic [2:0]  resp_type;
  logic [7:0]  resp_opaque;
  logic [1:0]  resp_test;
  logic [1:0]  resp_len;
  logic [31:0] resp_data;

  logic [31:0] mem [p_num_words];

  // Request field decode
  logic [2:0]       req_type_c;
  logic [7:0]       req_opaque_c;
  logic [31:0]      req_addr_c;
  logic [1:0]       req_len_c;
  logic [31:0]      req_data_c;
  logic [IDX_W-1:0] req_idx_c;

  assign req_type_c   = memreq_msg[76:74];
  assign req_opaque_c = memreq_msg[73:66];
  assign req_addr_c   = memreq_msg[65:34];
  assign req_len_c    = memreq_msg[33:32];
  assign req_data_c   = memreq_msg[31:0];
  assign req_idx_c    = req_addr_c[IDX_W+1:2];

  logic accept_c;
  logic is_wr_c;
  logic err_c;

  assign accept_c = memreq_val && (state == IDLE);
  assign is_wr_c  = (req_type_c == TYPE_WRITE) || (req_type_c == TYPE_INIT);

  // Out-of-range detection (only meaningful when the error feature is built)
`ifdef LAB3_MEM_RESP_ERR_EN
  assign err_c = (33'(req_addr_c) >= (33'(p_num_words) << 2));
`else
  logic unused_addr_hi_c;
  assign unused_addr_hi_c = |req_addr_c[31:IDX_W+2];
  assign err_c = 1'b0;
`endif

  // Byte-lane alignment: full-word accesses ignore the low address bits
  logic [1:0]  shift_c;
  logic [3:0]  len_mask_c;
  logic [3:0]  be_c;
  logic [31:0] wr_data_c;
  logic [31:0] rd_word_c;
  logic [31:0] rd_mask_c;
  logic [31:0] rd_data_c;

  always_comb begin
    shift_c    = (req_len_c == 2'd0) ? 2'd0 : req_addr_c[1:0];
    len_mask_c = (req_len_c == 2'd0) ? 4'hf : 4'((4'd1 << req_len_c) - 4'd1);
    be_c       = 4'(len_mask_c << shift_c);
    wr_data_c  = 32'(req_data_c << {shift_c, 3'b000});
    rd_word_c  = mem[req_idx_c];
    rd_mask_c  = (req_len_c == 2'd0) ? 32'hffff_ffff
                                     : 32'((32'd1 << {req_len_c, 3'b000}) - 32'd1);
    rd_data_c  = (rd_word_c >> {shift_c, 3'b000}) & rd_mask_c;
  end

  // Next-state and latency countdown
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (memreq_val) begin
          if (p_latency == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(p_latency);
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) state_next = RESP;
        else                  cnt_next   = cnt - CNT_W'(1);
      end
      RESP: begin
        if (memresp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, handshake flags and request counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      memreq_rdy  <= 1'b1;
      memresp_val <= 1'b0;
      num_reqs    <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      memreq_rdy  <= (state_next == IDLE);
      memresp_val <= (state_next == RESP);
      if (accept_c) num_reqs <= num_reqs + 32'd1;
    end
  end

  // Response payload captured at the accept edge, held until handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_type   <= '0;
      resp_opaque <= '0;
      resp_test   <= '0;
      resp_len    <= '0;
      resp_data   <= '0;
    end else if (accept_c) begin
      resp_type   <= req_type_c;
      resp_opaque <= req_opaque_c;
      resp_test   <= err_c ? 2'b11 : 2'b00;
      resp_len    <= req_len_c;
      resp_data   <= (is_wr_c || err_c) ? 32'd0 : rd_data_c;
    end
  end

  // Byte-enabled array update; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && accept_c && is_wr_c && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[req_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
      end
    end
  end

  assign memresp_msg = {resp_type, resp_opaque, resp_test, resp_len, resp_data};

endmodule

// File: tb/tb_lab3_test_mem_responder.sv
// Directed bench for lab3_test_mem_responder: instance 0 at latency 0,
// instance 1 at latency 3.
module tb_lab3_test_mem_responder;

  logic        clk = 1'b0;
  logic        rst      [2];
  logic        req_val  [2];
  logic        req_rdy  [2];
  logic [76:0] req_msg  [2];
  logic        resp_val [2];
  logic        resp_rdy [2];
  logic [46:0] resp_msg [2];
  logic [31:0] nreq     [2];

  int checks = 0;
  int errors = 0;
  int exp_n [2];

  always #5 clk = ~clk;

  lab3_test_mem_responder #(.p_num_words(4096), .p_latency(0)) dut0 (
    .clk(clk), .reset(rst[0]),
    .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]), .memreq_msg(req_msg[0]),
    .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0]), .memresp_msg(resp_msg[0]),
    .num_reqs(nreq[0])
  );

  lab3_test_mem_responder #(.p_num_words(4096), .p_latency(3)) dut1 (
    .clk(clk), .reset(rst[1]),
    .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]), .memreq_msg(req_msg[1]),
    .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1]), .memresp_msg(resp_msg[1]),
    .num_reqs(nreq[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [46:0] rmsg(input logic [2:0] ty, input logic [7:0] op,
                                       input logic [1:0] te, input logic [1:0] ln,
                                       input logic [31:0] dt);
    return {ty, op, te, ln, dt};
  endfunction

  // One complete transaction with latency and payload checks
  task automatic xact(input int d, input string tag, input logic [2:0] ty,
                      input logic [7:0] op, input logic [31:0] ad, input logic [1:0] ln,
                      input logic [31:0] dt, input logic [1:0] exp_t,
                      input logic [31:0] exp_d, input int exp_lat);
    int n;
    req_val[d] = 1'b1;
    req_msg[d] = {ty, op, ad, ln, dt};
    n = 0;
    while (!req_rdy[d] && n < 50) begin step(); n++; end
    check({tag, "_rdy_before"}, 64'(req_rdy[d]), 64'd1);
    step();
    req_val[d] = 1'b0;
    exp_n[d]++;
    if (exp_lat > 0) check({tag, "_rdy_busy"}, 64'(req_rdy[d]), 64'd0);
    n = 0;
    while (!resp_val[d] && n < 50) begin step(); n++; end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_msg"}, 64'(resp_msg[d]), 64'(rmsg(ty, op, exp_t, ln, exp_d)));
    check({tag, "_nreq"}, 64'(nreq[d]), 64'(exp_n[d]));
    step();
    check({tag, "_val_drop"}, 64'(resp_val[d]), 64'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_val[d] = 1'b0; req_msg[d] = '0; resp_rdy[d] = 1'b1; exp_n[d] = 0;
    end
    step(); step();
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Reset state of both instances
    for (int d = 0; d < 2; d++) begin
      check("reset_rdy", 64'(req_rdy[d]), 64'd1);
      check("reset_val", 64'(resp_val[d]), 64'd0);
      check("reset_msg", 64'(resp_msg[d]), 64'd0);
      check("reset_nreq", 64'(nreq[d]), 64'd0);
    end

    // Zero latency write then read
    xact(0, "l0_wr", 3'd1, 8'h01, 32'h100, 2'd0, 32'hdeadbeef, 2'b00, 32'h0, 0);
    xact(0, "l0_rd", 3'd0, 8'h02, 32'h100, 2'd0, 32'h0, 2'b00, 32'hdeadbeef, 0);

    // Sub-word writes and reads at latency 3
    xact(1, "wr_full", 3'd1, 8'h10, 32'h200, 2'd0, 32'h11223344, 2'b00, 32'h0, 3);
    xact(1, "wr_byte", 3'd1, 8'h11, 32'h201, 2'd1, 32'h000000aa, 2'b00, 32'h0, 3);
    xact(1, "rd_full", 3'd0, 8'h12, 32'h200, 2'd0, 32'h0, 2'b00, 32'h1122aa44, 3);
    xact(1, "rd_half", 3'd0, 8'h13, 32'h202, 2'd2, 32'h0, 2'b00, 32'h00001122, 3);
    xact(1, "rd_len0_off", 3'd0, 8'h14, 32'h203, 2'd0, 32'h0, 2'b00, 32'h1122aa44, 3);
    xact(1, "wr_w208", 3'd1, 8'h15, 32'h208, 2'd0, 32'h55667788, 2'b00, 32'h0, 3);
    xact(1, "wr_drop", 3'd1, 8'h16, 32'h20a, 2'd3, 32'h00ccbbaa, 2'b00, 32'h0, 3);
    xact(1, "rd_w208", 3'd0, 8'h17, 32'h208, 2'd0, 32'h0, 2'b00, 32'hbbaa7788, 3);
    xact(1, "rd_3b", 3'd0, 8'h18, 32'h209, 2'd3, 32'h0, 2'b00, 32'h00bbaa77, 3);
    xact(1, "rd_type7", 3'd7, 8'h19, 32'h200, 2'd0, 32'h0, 2'b00, 32'h1122aa44, 3);
`ifdef LAB3_MEM_RESP_ERR_EN
    xact(1, "oor_rd", 3'd0, 8'h1a, 32'h4200, 2'd0, 32'h0, 2'b11, 32'h0, 3);
    xact(1, "oor_wr", 3'd1, 8'h1b, 32'h4200, 2'd0, 32'h99999999, 2'b11, 32'h0, 3);
    xact(1, "oor_noeffect", 3'd0, 8'h1c, 32'h200, 2'd0, 32'h0, 2'b00, 32'h1122aa44, 3);
`else
    xact(1, "wrap_rd", 3'd0, 8'h1a, 32'h4200, 2'd0, 32'h0, 2'b00, 32'h1122aa44, 3);
`endif

    // Response backpressure: payload held, second request refused
    resp_rdy[1] = 1'b0;
    req_val[1]  = 1'b1;
    req_msg[1]  = {3'd0, 8'h55, 32'h200, 2'd0, 32'h0};
    step();
    exp_n[1]++;
    req_msg[1]  = {3'd1, 8'h66, 32'h200, 2'd0, 32'hffffffff};
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      check("stall_val", 64'(resp_val[1]), 64'd1);
      check("stall_msg", 64'(resp_msg[1]), 64'(rmsg(3'd0, 8'h55, 2'b00, 2'd0, 32'h1122aa44)));
      check("stall_rdy", 64'(req_rdy[1]), 64'd0);
      step();
    end
    check("stall_nreq", 64'(nreq[1]), 64'(exp_n[1]));
    resp_rdy[1] = 1'b1;
    req_val[1]  = 1'b0;
    step();
    check("stall_release_val", 64'(resp_val[1]), 64'd0);
    check("stall_release_rdy", 64'(req_rdy[1]), 64'd1);
    check("stall_release_nreq", 64'(nreq[1]), 64'(exp_n[1]));
    xact(1, "after_stall", 3'd0, 8'h1d, 32'h200, 2'd0, 32'h0, 2'b00, 32'h1122aa44, 3);

    // Reset while waiting drops the request
    req_val[1] = 1'b1;
    req_msg[1] = {3'd0, 8'h77, 32'h200, 2'd0, 32'h0};
    step();
    req_val[1] = 1'b0;
    step();
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    exp_n[1] = 0;
    check("rstwait_rdy", 64'(req_rdy[1]), 64'd1);
    check("rstwait_nreq", 64'(nreq[1]), 64'd0);
    for (int i = 0; i < 6; i++) begin
      check("rstwait_noresp", 64'(resp_val[1]), 64'd0);
      step();
    end
    xact(1, "rstwait_keep", 3'd0, 8'h78, 32'h208, 2'd0, 32'h0, 2'b00, 32'hbbaa7788, 3);
    xact(0, "l0_keep", 3'd0, 8'h03, 32'h100, 2'd0, 32'h0, 2'b00, 32'hdeadbeef, 0);

    // Cache line refill: fill via INIT, reset, then 16 ordered reads
    for (int i = 0; i < 16; i++)
      xact(1, "line_init", 3'd2, 8'(i), 32'h40 + 32'(4 * i), 2'd0, 32'hc0de0000 | 32'(i),
           2'b00, 32'h0, 3);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    exp_n[1] = 0;
    for (int i = 0; i < 16; i++)
      xact(1, "line_rd", 3'd0, 8'(i), 32'h40 + 32'(4 * i), 2'd0, 32'h0, 2'b00,
           32'hc0de0000 | 32'(i), 3);
    check("line_nreq", 64'(nreq[1]), 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
